// File: rtl/plic.sv
// Platform-level interrupt controller: per-source level gateways, priority/threshold
// arbitration, and a claim/complete register pair on the core's valid/ready bus.
module plic #(
  parameter int SOURCES = 8,
  parameter int PRIO_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SOURCES:0] irq_src,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic             mem_ready,
  output logic             extern_irpt
);
  localparam int         ID_W    = 5;
  localparam logic [7:0] A_PEND  = 8'h20;
  localparam logic [7:0] A_EN    = 8'h40;
  localparam logic [7:0] A_TH    = 8'h80;
  localparam logic [7:0] A_CLAIM = 8'h81;

  typedef enum logic {S_IDLE, S_RESP} state_t;
  state_t r_state, w_state_nx;

  logic [PRIO_W-1:0] r_prio [1:SOURCES];
  logic [PRIO_W-1:0] r_thresh;
  logic [SOURCES:0]  r_pending, r_inflight, r_enable;
  logic [SOURCES:0]  w_pending_nx, w_inflight_nx;
  logic [31:0]       r_rdata, w_rdata;
  logic              r_irpt;

  logic              w_access, w_wr, w_rd, w_claim, w_complete;
  logic [7:0]        w_word;
  logic [ID_W-1:0]   w_cid, w_max_id;
  logic [PRIO_W-1:0] w_best;
  logic              w_unused;

  assign w_word     = mem_addr[9:2];
  assign w_cid      = mem_wdata[ID_W-1:0];
  assign w_wr       = w_access && (mem_wstrb != 4'h0);
  assign w_rd       = w_access && (mem_wstrb == 4'h0);
  assign w_claim    = w_rd && (w_word == A_CLAIM);
  assign w_complete = w_wr && (w_word == A_CLAIM);
  assign w_unused   = ^{mem_addr, mem_wdata, irq_src[0]};

  assign mem_rdata   = r_rdata;
  assign extern_irpt = r_irpt;

  // Bus FSM; the ready pulse is suppressed while reset is held so an aborted
  // access never completes.
  always_comb begin
    w_state_nx = r_state;
    w_access   = 1'b0;
    mem_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          w_access   = 1'b1;
          w_state_nx = S_RESP;
        end
      end
      S_RESP: begin
        mem_ready  = rst;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // Winner: highest priority above threshold; strict compare keeps the lowest ID on ties.
  always_comb begin
    w_max_id = '0;
    w_best   = '0;
    for (int i = 1; i <= SOURCES; i++) begin
      if (r_pending[i] && r_enable[i] && (r_prio[i] > r_thresh) && (r_prio[i] > w_best)) begin
        w_best   = r_prio[i];
        w_max_id = ID_W'(i);
      end
    end
  end

  // Gateways: a claim beats a simultaneous new request, and inflight blocks re-pending
  // until the matching complete has been registered.
  assign w_pending_nx[0]  = 1'b0;
  assign w_inflight_nx[0] = 1'b0;
  for (genvar gi = 1; gi <= SOURCES; gi++) begin : g_gw
    logic w_claim_hit, w_comp_hit;
    assign w_claim_hit       = w_claim && (w_max_id == ID_W'(gi));
    assign w_comp_hit        = w_complete && (w_cid == ID_W'(gi));
    assign w_pending_nx[gi]  = w_claim_hit ? 1'b0 : (r_pending[gi] | (irq_src[gi] & ~r_inflight[gi]));
    assign w_inflight_nx[gi] = w_claim_hit | (r_inflight[gi] & ~w_comp_hit);
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 1; i <= SOURCES; i++) begin
      if (w_word == 8'(i)) w_rdata[PRIO_W-1:0] = r_prio[i];
    end
    case (w_word)
      A_PEND:  w_rdata[SOURCES:0] = r_pending;
      A_EN:    w_rdata[SOURCES:0] = r_enable;
      A_TH:    w_rdata[PRIO_W-1:0] = r_thresh;
      A_CLAIM: w_rdata[ID_W-1:0] = w_max_id;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i <= SOURCES; i++) r_prio[i] <= '0;
      r_thresh   <= '0;
      r_enable   <= '0;
      r_pending  <= '0;
      r_inflight <= '0;
      r_rdata    <= '0;
      r_irpt     <= 1'b0;
    end else begin
      r_pending  <= w_pending_nx;
      r_inflight <= w_inflight_nx;
      r_irpt     <= (w_max_id != '0);
      if (w_access) r_rdata <= w_rdata;
      if (w_wr) begin
        for (int i = 1; i <= SOURCES; i++) begin
          if (w_word == 8'(i)) r_prio[i] <= mem_wdata[PRIO_W-1:0];
        end
        if (w_word == A_EN) r_enable <= {mem_wdata[SOURCES:1], 1'b0};
        if (w_word == A_TH) r_thresh <= mem_wdata[PRIO_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_plic.sv
// Directed bench for plic: bus reads are queued with their expected data and
// checked by an independent monitor whenever mem_ready pulses.
module tb_plic;
  localparam logic [9:0] A_PEND  = 10'h080;
  localparam logic [9:0] A_EN    = 10'h100;
  localparam logic [9:0] A_TH    = 10'h200;
  localparam logic [9:0] A_CLAIM = 10'h204;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  irq_src = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        extern_irpt;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          chk;
  } sb_t;
  sb_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  plic #(.SOURCES(8), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .extern_irpt(extern_irpt)
  );

  always #5 clk = ~clk;

  // Monitor: every response pulse must match the oldest outstanding request.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ready: got mem_ready=1, required no response");
        end else begin
          e = sb_q.pop_front();
          if (e.chk) begin
            vectors++;
            if (mem_rdata !== e.exp) begin
              miscompares++;
              $display("FAIL %s: got rdata=%h, required %h", e.name, mem_rdata, e.exp);
            end else begin
              $display("rd %s rdata=%h", e.name, mem_rdata);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic [9:0] a, input bit wr, input logic [31:0] d,
                     input logic [31:0] exp, input string nm);
    sb_t e;
    int  n;
    e.name = nm;
    e.exp  = exp;
    e.chk  = !wr;
    sb_q.push_back(e);
    mem_addr  = {22'd0, a};
    mem_wdata = d;
    mem_wstrb = wr ? 4'hF : 4'h0;
    mem_valid = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!mem_ready && n < 8);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    if (!mem_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: mem_ready=0 after %0d cycles, required 1", nm, n);
      sb_q.delete(sb_q.size() - 1);
    end else if (wr) begin
      $display("wr %s addr=%h data=%h", nm, a, d);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input string nm);
    bus(a, 1'b1, d, 32'h0, nm);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string nm);
    bus(a, 1'b0, 32'h0, exp, nm);
  endtask

  task automatic chk_irpt(input logic exp, input string nm);
    vectors++;
    if (extern_irpt !== exp) begin
      miscompares++;
      $display("FAIL %s: got extern_irpt=%b, required %b", nm, extern_irpt, exp);
    end else begin
      $display("chk %s extern_irpt=%b", nm, extern_irpt);
    end
  endtask

  initial begin
    tick(3);
    rst = 1'b1;
    tick(1);
    chk_irpt(1'b0, "reset_irpt");
    rd(A_CLAIM, 32'h0, "reset_claim");
    rd(10'h008, 32'h0, "reset_prio2");

    // 1: single source, two-edge request latency, claim drops the request
    wr(10'h00C, 32'h2, "prio3");
    wr(A_EN, 32'h08, "en");
    wr(A_TH, 32'h0, "th");
    irq_src[3] = 1'b1;
    tick(1);
    chk_irpt(1'b0, "t1_one_edge");
    tick(1);
    chk_irpt(1'b1, "t1_two_edges");
    rd(A_CLAIM, 32'd3, "t1_claim");
    chk_irpt(1'b1, "t1_claim_edge");
    tick(1);
    chk_irpt(1'b0, "t1_after_claim");
    rd(A_PEND, 32'h0, "t1_pending");
    irq_src[3] = 1'b0;
    wr(A_CLAIM, 32'd3, "complete3");

    // 2: arbitration order with tie, plus ignored/unmapped accesses
    wr(10'h008, 32'h5, "prio2");
    wr(10'h014, 32'h5, "prio5");
    wr(10'h018, 32'h1, "prio6");
    wr(A_EN, 32'h6D, "en");
    rd(A_EN, 32'h6C, "t2_en_bit0");
    rd(10'h008, 32'h5, "t2_prio2");
    wr(10'h000, 32'h7, "prio0");
    rd(10'h000, 32'h0, "t2_prio0");
    wr(A_PEND, 32'hFFFF, "pend_ro");
    rd(A_PEND, 32'h0, "t2_pend_ro");
    rd(10'h300, 32'h0, "t2_unmapped");
    irq_src[2] = 1'b1;
    irq_src[5] = 1'b1;
    irq_src[6] = 1'b1;
    tick(2);
    rd(A_CLAIM, 32'd2, "t2_claim_a");
    irq_src[2] = 1'b0;
    wr(A_CLAIM, 32'd2, "complete2");
    rd(A_CLAIM, 32'd5, "t2_claim_b");
    irq_src[5] = 1'b0;
    wr(A_CLAIM, 32'd5, "complete5");
    rd(A_CLAIM, 32'd6, "t2_claim_c");
    irq_src[6] = 1'b0;
    wr(A_CLAIM, 32'd6, "complete6");
    rd(A_CLAIM, 32'd0, "t2_claim_d");
    chk_irpt(1'b0, "t2_idle");

    // 3: priority equal to threshold does not interrupt
    wr(A_TH, 32'h4, "th");
    wr(10'h004, 32'h4, "prio1");
    wr(A_EN, 32'h6E, "en");
    irq_src[1] = 1'b1;
    tick(3);
    chk_irpt(1'b0, "t3_at_threshold");
    rd(A_CLAIM, 32'd0, "t3_claim_none");
    rd(A_PEND, 32'h02, "t3_pending");
    wr(A_TH, 32'h3, "th");
    tick(1);
    chk_irpt(1'b1, "t3_th_lowered");
    rd(A_CLAIM, 32'd1, "t3_claim");
    irq_src[1] = 1'b0;
    wr(A_CLAIM, 32'd1, "complete1");
    wr(A_TH, 32'h0, "th");

    // 4: complete re-arms a held source; bad IDs are ignored
    wr(10'h010, 32'h3, "prio4");
    wr(A_EN, 32'h7E, "en");
    irq_src[4] = 1'b1;
    tick(2);
    rd(A_CLAIM, 32'd4, "t4_claim");
    rd(A_PEND, 32'h0, "t4_pend_claimed");
    wr(A_CLAIM, 32'd9, "complete9");
    wr(A_CLAIM, 32'd0, "complete0");
    rd(A_PEND, 32'h0, "t4_pend_badids");
    chk_irpt(1'b0, "t4_inflight");
    wr(A_CLAIM, 32'd4, "complete4");
    tick(1);
    chk_irpt(1'b0, "t4_pend_edge");
    tick(1);
    chk_irpt(1'b1, "t4_reassert");
    rd(A_PEND, 32'h10, "t4_repend");
    rd(A_CLAIM, 32'd4, "t4_claim2");
    irq_src[4] = 1'b0;
    wr(A_CLAIM, 32'd4, "complete4");

    // 5: claim collides with a held line
    irq_src[3] = 1'b1;
    tick(2);
    rd(A_CLAIM, 32'd3, "t5_claim");
    tick(1);
    rd(A_PEND, 32'h0, "t5_pend_blocked");
    wr(A_CLAIM, 32'd3, "complete3");
    rd(A_PEND, 32'h08, "t5_pend_rearmed");
    rd(A_CLAIM, 32'd3, "t5_claim2");
    irq_src[3] = 1'b0;
    wr(A_CLAIM, 32'd3, "complete3");

    // 6: reset during the response cycle of a claim
    wr(A_TH, 32'h1, "th");
    irq_src[2] = 1'b1;
    tick(2);
    chk_irpt(1'b1, "t6_pre_reset");
    mem_addr  = {22'd0, A_CLAIM};
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    tick(1);
    rst = 1'b0;
    mem_valid = 1'b0;
    irq_src = '0;
    $display("rst asserted during claim response");
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_irpt(1'b0, "t6_irpt_after_reset");
    rd(10'h008, 32'h0, "t6_prio2");
    rd(10'h00C, 32'h0, "t6_prio3");
    rd(A_EN, 32'h0, "t6_en");
    rd(A_TH, 32'h0, "t6_th");
    rd(A_PEND, 32'h0, "t6_pend");
    rd(A_CLAIM, 32'h0, "t6_claim");
    wr(10'h008, 32'h5, "prio2");
    wr(A_EN, 32'h04, "en");
    irq_src[2] = 1'b1;
    tick(2);
    chk_irpt(1'b1, "t6_inflight_cleared");
    irq_src[2] = 1'b0;

    tick(3);
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL outstanding: got %0d unanswered requests, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
